// File: rtl/alu_cmd_issuer_if.sv
// Bundle of the command, ALU and response signals around alu_cmd_issuer.
// master: the issuer itself (accepts commands, drives the ALU, returns results).
// slave:  its surroundings (command source, ALU outputs, result consumer).
interface alu_cmd_issuer_if #(
  parameter int OP_DATA_WIDTH   = 16,
  parameter int Arith_OUT_WIDTH = 2 * OP_DATA_WIDTH,
  parameter int CMP_OUT_WIDTH   = 2
);

  // command handshake
  logic                       CMD_VALID;
  logic                       CMD_READY;
  logic [3:0]                 CMD_FUN;
  logic [OP_DATA_WIDTH-1:0]   CMD_A;
  logic [OP_DATA_WIDTH-1:0]   CMD_B;

  // ALU inputs (driven by the issuer)
  logic [OP_DATA_WIDTH-1:0]   ALU_A;
  logic [OP_DATA_WIDTH-1:0]   ALU_B;
  logic [3:0]                 ALU_FUN;

  // ALU outputs (observed by the issuer)
  logic [Arith_OUT_WIDTH-1:0] Arith_OUT;
  logic                       Carry_OUT;
  logic                       Arith_Flag;
  logic                       Logic_Flag;
  logic                       CMP_Flag;
  logic                       Shift_Flag;
  logic [OP_DATA_WIDTH-1:0]   Logic_OUT;
  logic [CMP_OUT_WIDTH-1:0]   CMP_OUT;
  logic [OP_DATA_WIDTH-1:0]   Shift_OUT;

  // result handshake
  logic                       RES_VALID;
  logic                       RES_READY;
  logic [Arith_OUT_WIDTH-1:0] RES_DATA;
  logic                       RES_CARRY;
  logic [1:0]                 RES_UNIT;
  logic                       RES_ERR;
  logic [7:0]                 ERR_CNT;

  modport master (
    input  CMD_VALID, CMD_FUN, CMD_A, CMD_B,
    output CMD_READY,
    output ALU_A, ALU_B, ALU_FUN,
    input  Arith_OUT, Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
    input  Logic_OUT, CMP_OUT, Shift_OUT,
    output RES_VALID, RES_DATA, RES_CARRY, RES_UNIT, RES_ERR, ERR_CNT,
    input  RES_READY
  );

  modport slave (
    output CMD_VALID, CMD_FUN, CMD_A, CMD_B,
    input  CMD_READY,
    input  ALU_A, ALU_B, ALU_FUN,
    output Arith_OUT, Carry_OUT, Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag,
    output Logic_OUT, CMP_OUT, Shift_OUT,
    input  RES_VALID, RES_DATA, RES_CARRY, RES_UNIT, RES_ERR, ERR_CNT,
    output RES_READY
  );

endinterface

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: command front-end that initiates operations on ALU_TOP.
// One {opcode, A, B} command is accepted in IDLE and registered onto the ALU
// inputs. The block then waits out the ALU's registered latency and watches the
// unit flags. A matching flag captures the unit's result, zero-extended to the
// arithmetic width. If no match arrives within TIMEOUT extra cycles, an error
// response is produced instead. The response is held in RESP until the
// consumer accepts it.
// Optional build macro DIV_ZERO_CHECK_EN: when it is defined, a divide
// (4'b0011) with B==0 is never sent to the ALU and is answered at once with
// an error response.
module alu_cmd_issuer #(
  parameter int OP_DATA_WIDTH   = 16,
  parameter int Arith_OUT_WIDTH = 2 * OP_DATA_WIDTH,
  parameter int CMP_OUT_WIDTH   = 2,
  parameter int ALU_LATENCY     = 1,
  parameter int TIMEOUT         = 4
) (
  input logic              CLK,
  input logic              RST,
  alu_cmd_issuer_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Counter compare points. ALU_LATENCY and TIMEOUT are each at most 15,
  // so their sum always fits in five bits.
  localparam logic [4:0] LAT_C   = 5'(ALU_LATENCY);
  localparam logic [4:0] LIMIT_C = 5'(ALU_LATENCY + TIMEOUT);

  localparam logic [3:0] FUN_DIV = 4'b0011;

  state_t                     state_q, state_d;
  logic [4:0]                 cnt_q, cnt_d;
  logic [OP_DATA_WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [OP_DATA_WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [3:0]                 alu_fun_q, alu_fun_d;
  logic [1:0]                 unit_q, unit_d;
  logic [Arith_OUT_WIDTH-1:0] res_data_q, res_data_d;
  logic                       res_carry_q, res_carry_d;
  logic                       res_err_q, res_err_d;
  logic [7:0]                 err_cnt_q, err_cnt_d;

  logic [3:0]                 flags;
  logic [3:0]                 exp_flags;
  logic [Arith_OUT_WIDTH-1:0] sel_data;
  logic                       sel_carry;
  logic                       reject_cmd;
  logic [7:0]                 err_cnt_inc;

  // Flag vector as the ALU presents it, and the one that the issued opcode's
  // unit should raise ({Arith, Logic, CMP, Shift}, one-hot by unit class).
  always_comb begin
    flags     = {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag};
    exp_flags = 4'b1000 >> alu_fun_q[3:2];
  end

  // Pick the issued unit's output and normalise it to the arithmetic width;
  // only the arithmetic unit passes its carry through.
  always_comb begin
    sel_data  = '0;
    sel_carry = 1'b0;
    case (alu_fun_q[3:2])
      2'b00: begin
        sel_data  = bus.Arith_OUT;
        sel_carry = bus.Carry_OUT;
      end
      2'b01: sel_data[OP_DATA_WIDTH-1:0] = bus.Logic_OUT;
      2'b10: sel_data[CMP_OUT_WIDTH-1:0] = bus.CMP_OUT;
      default: sel_data[OP_DATA_WIDTH-1:0] = bus.Shift_OUT;
    endcase
  end

  // Decide whether an incoming command is refused without reaching the ALU.
  always_comb begin
    reject_cmd = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    if ((bus.CMD_FUN == FUN_DIV) && (bus.CMD_B == '0)) begin
      reject_cmd = 1'b1;
    end
`else
    if (bus.CMD_FUN == FUN_DIV) begin
      reject_cmd = 1'b0;
    end
`endif
  end

  // Error count steps by one per errored response and sticks at 8'hFF.
  always_comb begin
    err_cnt_inc = err_cnt_q;
    if (err_cnt_q != 8'hFF) begin
      err_cnt_inc = err_cnt_q + 8'd1;
    end
  end

  // Next-state logic: accept, wait for the flag or time out, then hold the
  // response until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fun_d   = alu_fun_q;
    unit_d      = unit_q;
    res_data_d  = res_data_q;
    res_carry_d = res_carry_q;
    res_err_d   = res_err_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.CMD_VALID) begin
          if (reject_cmd) begin
            unit_d      = 2'b00;
            res_data_d  = '0;
            res_carry_d = 1'b0;
            res_err_d   = 1'b1;
            err_cnt_d   = err_cnt_inc;
            state_d     = ST_RESP;
          end else begin
            alu_a_d   = bus.CMD_A;
            alu_b_d   = bus.CMD_B;
            alu_fun_d = bus.CMD_FUN;
            unit_d    = bus.CMD_FUN[3:2];
            // cnt holds 1 during the first WAIT cycle
            cnt_d     = 5'd1;
            state_d   = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        cnt_d = cnt_q + 5'd1;
        if ((cnt_q > LAT_C) && (flags == exp_flags)) begin
          res_data_d  = sel_data;
          res_carry_d = sel_carry;
          res_err_d   = 1'b0;
          state_d     = ST_RESP;
        end else if (cnt_q == LIMIT_C) begin
          res_data_d  = '0;
          res_carry_d = 1'b0;
          res_err_d   = 1'b1;
          err_cnt_d   = err_cnt_inc;
          state_d     = ST_RESP;
        end
      end

      ST_RESP: begin
        if (bus.RES_READY) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= 4'b0000;
      unit_q      <= 2'b00;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_err_q   <= 1'b0;
      err_cnt_q   <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fun_q   <= alu_fun_d;
      unit_q      <= unit_d;
      res_data_q  <= res_data_d;
      res_carry_q <= res_carry_d;
      res_err_q   <= res_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  // Handshake outputs follow the state directly; everything else is a register.
  always_comb begin
    bus.CMD_READY = (state_q == ST_IDLE);
    bus.RES_VALID = (state_q == ST_RESP);
    bus.ALU_A     = alu_a_q;
    bus.ALU_B     = alu_b_q;
    bus.ALU_FUN   = alu_fun_q;
    bus.RES_DATA  = res_data_q;
    bus.RES_CARRY = res_carry_q;
    bus.RES_UNIT  = unit_q;
    bus.RES_ERR   = res_err_q;
    bus.ERR_CNT   = err_cnt_q;
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed testbench for alu_cmd_issuer with a one-cycle registered ALU model.
module tb_alu_cmd_issuer;

  localparam int W  = 16;
  localparam int AW = 32;

  logic CLK = 1'b0;
  logic RST;
  logic forceNoFlags;

  int total = 0;
  int bad   = 0;

  alu_cmd_issuer_if #(.OP_DATA_WIDTH(W), .Arith_OUT_WIDTH(AW), .CMP_OUT_WIDTH(2)) bus ();

  alu_cmd_issuer #(
    .OP_DATA_WIDTH(W), .Arith_OUT_WIDTH(AW), .CMP_OUT_WIDTH(2),
    .ALU_LATENCY(1), .TIMEOUT(4)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU_TOP: one registered stage, only the selected unit drives
  // its output and flag; forceNoFlags suppresses every flag.
  always @(posedge CLK) begin
    int ia, ib;
    logic [W:0] usum;
    ia   = $signed(bus.ALU_A);
    ib   = $signed(bus.ALU_B);
    usum = {1'b0, bus.ALU_A} + {1'b0, bus.ALU_B};
    bus.Arith_OUT <= '0;
    bus.Carry_OUT <= 1'b0;
    bus.Logic_OUT <= '0;
    bus.CMP_OUT   <= '0;
    bus.Shift_OUT <= '0;
    case (bus.ALU_FUN)
      4'b0000: begin bus.Arith_OUT <= ia + ib; bus.Carry_OUT <= usum[W]; end
      4'b0001: bus.Arith_OUT <= ia - ib;
      4'b0010: bus.Arith_OUT <= ia * ib;
      4'b0011: bus.Arith_OUT <= (ib == 0) ? 0 : ia / ib;
      4'b0100: bus.Logic_OUT <= bus.ALU_A & bus.ALU_B;
      4'b0101: bus.Logic_OUT <= bus.ALU_A | bus.ALU_B;
      4'b0110: bus.Logic_OUT <= ~(bus.ALU_A & bus.ALU_B);
      4'b0111: bus.Logic_OUT <= ~(bus.ALU_A | bus.ALU_B);
      4'b1000: bus.CMP_OUT   <= 2'd0;
      4'b1001: bus.CMP_OUT   <= (ia == ib) ? 2'd1 : 2'd0;
      4'b1010: bus.CMP_OUT   <= (ia > ib)  ? 2'd2 : 2'd0;
      4'b1011: bus.CMP_OUT   <= (ia < ib)  ? 2'd3 : 2'd0;
      4'b1100: bus.Shift_OUT <= bus.ALU_A >> 1;
      4'b1101: bus.Shift_OUT <= bus.ALU_A << 1;
      4'b1110: bus.Shift_OUT <= bus.ALU_B >> 1;
      default: bus.Shift_OUT <= bus.ALU_B << 1;
    endcase
    {bus.Arith_Flag, bus.Logic_Flag, bus.CMP_Flag, bus.Shift_Flag}
      <= forceNoFlags ? 4'b0000 : (4'b1000 >> bus.ALU_FUN[3:2]);
  end

  // Advance to just after the next rising edge.
  task automatic stepCycle();
    @(posedge CLK);
    #1;
  endtask

  // One comparison: counted, and reported on mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present a command in the current (IDLE) cycle; returns in cycle N+1.
  task automatic applyStimulus(input logic [3:0] fun, input logic [15:0] a,
                               input logic [15:0] b);
    bus.CMD_FUN   = fun;
    bus.CMD_A     = a;
    bus.CMD_B     = b;
    bus.CMD_VALID = 1'b1;
    checkOutput("cmd_ready_at_issue", 32'(bus.CMD_READY), 32'd1);
    stepCycle();
    bus.CMD_VALID = 1'b0;
  endtask

  // Hard stop if the run ever stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RST           = 1'b1;
    forceNoFlags  = 1'b0;
    bus.CMD_VALID = 1'b0;
    bus.CMD_FUN   = 4'h0;
    bus.CMD_A     = '0;
    bus.CMD_B     = '0;
    bus.RES_READY = 1'b1;
    stepCycle();
    stepCycle();

    // Reset state
    checkOutput("rst_cmd_ready", 32'(bus.CMD_READY), 32'd1);
    checkOutput("rst_res_valid", 32'(bus.RES_VALID), 32'd0);
    checkOutput("rst_alu_fun",   32'(bus.ALU_FUN),   32'd0);
    checkOutput("rst_alu_a",     32'(bus.ALU_A),     32'd0);
    checkOutput("rst_res_data",  bus.RES_DATA,       32'd0);
    checkOutput("rst_err_cnt",   32'(bus.ERR_CNT),   32'd0);
    RST = 1'b0;
    stepCycle();

    // Add -4 + -5: result in N+3, sign-extended, carry out of 16 bits
    applyStimulus(4'b0000, 16'hFFFC, 16'hFFFB);
    checkOutput("add_alu_a_n1",  32'(bus.ALU_A),     32'h0000FFFC);
    checkOutput("add_ready_n1",  32'(bus.CMD_READY), 32'd0);
    checkOutput("add_valid_n1",  32'(bus.RES_VALID), 32'd0);
    stepCycle();
    checkOutput("add_valid_n2",  32'(bus.RES_VALID), 32'd0);
    stepCycle();
    checkOutput("add_valid_n3",  32'(bus.RES_VALID), 32'd1);
    checkOutput("add_data",      bus.RES_DATA,       32'hFFFFFFF7);
    checkOutput("add_unit",      32'(bus.RES_UNIT),  32'd0);
    checkOutput("add_err",       32'(bus.RES_ERR),   32'd0);
    checkOutput("add_carry",     32'(bus.RES_CARRY), 32'd1);
    stepCycle();
    checkOutput("add_back_idle", 32'(bus.CMD_READY), 32'd1);
    checkOutput("add_alu_hold",  32'(bus.ALU_B),     32'h0000FFFB);

    // NAND 1, 0xB: zero-extended logic result
    applyStimulus(4'b0110, 16'h0001, 16'h000B);
    stepCycle();
    stepCycle();
    checkOutput("nand_valid",    32'(bus.RES_VALID), 32'd1);
    checkOutput("nand_data",     bus.RES_DATA,       32'h0000FFFE);
    checkOutput("nand_unit",     32'(bus.RES_UNIT),  32'd1);
    checkOutput("nand_carry",    32'(bus.RES_CARRY), 32'd0);
    stepCycle();

    // LT 4 < 5 with back-pressure; a second command waits until acceptance
    bus.RES_READY = 1'b0;
    applyStimulus(4'b1011, 16'd4, 16'd5);
    stepCycle();
    stepCycle();
    checkOutput("lt_valid",      32'(bus.RES_VALID), 32'd1);
    checkOutput("lt_data",       bus.RES_DATA,       32'd3);
    checkOutput("lt_unit",       32'(bus.RES_UNIT),  32'd2);
    bus.CMD_FUN   = 4'b0001;
    bus.CMD_A     = 16'd7;
    bus.CMD_B     = 16'd2;
    bus.CMD_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stepCycle();
      checkOutput("hold_valid",  32'(bus.RES_VALID), 32'd1);
      checkOutput("hold_data",   bus.RES_DATA,       32'd3);
      checkOutput("hold_ready",  32'(bus.CMD_READY), 32'd0);
      checkOutput("hold_alu_fun", 32'(bus.ALU_FUN),  32'hB);
    end
    bus.RES_READY = 1'b1;
    stepCycle();
    checkOutput("rel_ready",     32'(bus.CMD_READY), 32'd1);
    checkOutput("rel_valid",     32'(bus.RES_VALID), 32'd0);
    stepCycle();
    bus.CMD_VALID = 1'b0;
    checkOutput("sub_alu_fun",   32'(bus.ALU_FUN),   32'd1);
    stepCycle();
    stepCycle();
    checkOutput("sub_valid",     32'(bus.RES_VALID), 32'd1);
    checkOutput("sub_data",      bus.RES_DATA,       32'd5);
    stepCycle();

    // No flags: timeout at cnt==5 gives the error response in N+6
    forceNoFlags = 1'b1;
    applyStimulus(4'b0000, 16'd1, 16'd1);
    repeat (4) stepCycle();
    checkOutput("to_valid_n5",   32'(bus.RES_VALID), 32'd0);
    stepCycle();
    checkOutput("to_valid_n6",   32'(bus.RES_VALID), 32'd1);
    checkOutput("to_err",        32'(bus.RES_ERR),   32'd1);
    checkOutput("to_data",       bus.RES_DATA,       32'd0);
    checkOutput("to_carry",      32'(bus.RES_CARRY), 32'd0);
    checkOutput("to_err_cnt",    32'(bus.ERR_CNT),   32'd1);
    stepCycle();

    // Drive the error count to its ceiling, then one past it
    for (int i = 0; i < 254; i++) begin
      applyStimulus(4'b0100, 16'd3, 16'd1);
      repeat (6) stepCycle();
    end
    checkOutput("err_cnt_ff",    32'(bus.ERR_CNT),   32'hFF);
    applyStimulus(4'b0100, 16'd3, 16'd1);
    repeat (6) stepCycle();
    checkOutput("err_cnt_sat",   32'(bus.ERR_CNT),   32'hFF);
    forceNoFlags = 1'b0;

    // Reset during WAIT aborts the operation with no response
    applyStimulus(4'b0001, 16'd9, 16'd3);
    RST = 1'b1;
    stepCycle();
    RST = 1'b0;
    checkOutput("abort_ready",   32'(bus.CMD_READY), 32'd1);
    checkOutput("abort_valid",   32'(bus.RES_VALID), 32'd0);
    checkOutput("abort_alu_fun", 32'(bus.ALU_FUN),   32'd0);
    checkOutput("abort_err_cnt", 32'(bus.ERR_CNT),   32'd0);
    for (int i = 0; i < 4; i++) begin
      stepCycle();
      checkOutput("abort_no_resp", 32'(bus.RES_VALID), 32'd0);
    end

    // OR 3|4 leaves a known opcode on the ALU inputs
    applyStimulus(4'b0101, 16'd3, 16'd4);
    stepCycle();
    stepCycle();
    checkOutput("or_data",       bus.RES_DATA,       32'd7);
    stepCycle();

`ifdef DIV_ZERO_CHECK_EN
    // Divide by zero is refused: error response in N+1, ALU untouched
    applyStimulus(4'b0011, 16'd10, 16'd0);
    checkOutput("dz_valid_n1",   32'(bus.RES_VALID), 32'd1);
    checkOutput("dz_err",        32'(bus.RES_ERR),   32'd1);
    checkOutput("dz_data",       bus.RES_DATA,       32'd0);
    checkOutput("dz_unit",       32'(bus.RES_UNIT),  32'd0);
    checkOutput("dz_alu_fun",    32'(bus.ALU_FUN),   32'h5);
    checkOutput("dz_alu_b",      32'(bus.ALU_B),     32'd4);
    checkOutput("dz_err_cnt",    32'(bus.ERR_CNT),   32'd1);
    stepCycle();
`else
    // Divide by zero is issued normally; the model answers 0 with its flag
    applyStimulus(4'b0011, 16'd10, 16'd0);
    checkOutput("dz_alu_fun",    32'(bus.ALU_FUN),   32'h3);
    checkOutput("dz_valid_n1",   32'(bus.RES_VALID), 32'd0);
    stepCycle();
    stepCycle();
    checkOutput("dz_valid_n3",   32'(bus.RES_VALID), 32'd1);
    checkOutput("dz_err",        32'(bus.RES_ERR),   32'd0);
    checkOutput("dz_data",       bus.RES_DATA,       32'd0);
    checkOutput("dz_err_cnt",    32'(bus.ERR_CNT),   32'd0);
    stepCycle();
`endif

    // Signed divide -10 / 5
    applyStimulus(4'b0011, 16'hFFF6, 16'd5);
    stepCycle();
    stepCycle();
    checkOutput("div_valid",     32'(bus.RES_VALID), 32'd1);
    checkOutput("div_data",      bus.RES_DATA,       32'hFFFFFFFE);
    checkOutput("div_err",       32'(bus.RES_ERR),   32'd0);
    stepCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
